// File: rtl/prism_cfg_pkg.sv
// Shared definitions for the PRISM configuration bank: register map,
// register bit positions, sequencer states and the byte-lane helper.
package prism_cfg_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_STAGE_LO = 6'h04;
  localparam logic [5:0] ADDR_STAGE_HI = 6'h08;
  localparam logic [5:0] ADDR_STATUS   = 6'h0C;
  localparam logic [5:0] ADDR_RD_SEL   = 6'h10;
  localparam logic [5:0] ADDR_RD_LO    = 6'h14;
  localparam logic [5:0] ADDR_RD_HI    = 6'h18;

  localparam int CTRL_MODE    = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_IDX_LSB = 8;
  localparam int CTRL_LOCK    = 15;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_LOCK_ERR = 3;
  localparam int STAT_CNT_LSB  = 8;

  localparam logic [1:0] WN_B8   = 2'b00;
  localparam logic [1:0] WN_B16  = 2'b01;
  localparam logic [1:0] WN_B32  = 2'b10;
  localparam logic [1:0] WN_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_INDEX = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Bits of a 32-bit register touched by a bus write of the given size
  function automatic logic [31:0] lane_mask(input logic [1:0] wn);
    logic [31:0] m;
    case (wn)
      WN_B8:   m = 32'h0000_00FF;
      WN_B16:  m = 32'h0000_FFFF;
      WN_B32:  m = 32'hFFFF_FFFF;
      WN_NONE: m = 32'h0000_0000;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/prism_cfg_store.sv
// DEPTH x WIDTH configuration storage. Each entry loads only on its own
// enable, from its lower neighbour (shift) or from the staging word.
module prism_cfg_store
  import prism_cfg_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DEPTH-1:0]         en,
  input  logic                     shift_sel,
  input  logic [WIDTH-1:0]         staging,
  output logic [WIDTH*DEPTH-1:0]   config_bus
);

  logic [WIDTH-1:0] entry_r [DEPTH];
  logic [WIDTH-1:0] src_s   [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    if (g == 0) begin : g_head
      assign src_s[g] = staging;
    end else begin : g_link
      assign src_s[g] = shift_sel ? entry_r[g-1] : staging;
    end
    assign config_bus[g*WIDTH +: WIDTH] = entry_r[g];
  end

  // Per-entry load; reset clears the whole chain asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (en[i]) begin
          entry_r[i] <= src_s[i];
        end
      end
    end
  end

endmodule

// File: rtl/prism_cfg_bank.sv
// PRISM configuration bank: bus register file, staging word, commit
// sequencer and readback path around the entry store.
module prism_cfg_bank
  import prism_cfg_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             address,
  input  logic [31:0]            data_in,
  input  logic [1:0]             data_write_n,
  input  logic [1:0]             data_read_n,
  output logic [31:0]            data_out,
  output logic                   data_ready,
  output logic                   user_interrupt,
  output logic [WIDTH*DEPTH-1:0] config_bus
);

  localparam int IW = $clog2(DEPTH);

  state_e           state_r, state_next_s;
  logic [IW-1:0]    ptr_r, ptr_next_s;
  logic [DEPTH-1:0] en_s;
  logic             shift_sel_s, done_set_s;

  logic [WIDTH-1:0] stage_r;
  logic             mode_r, irq_en_r, lock_r;
  logic [IW-1:0]    wr_idx_r, rd_sel_r;
  logic             done_r, overrun_r, lock_err_r;
  logic [7:0]       cnt_r;

  logic             busy_s, wr_s, commit_req_s, commit_go_s;
  logic [31:0]      wmask_s, ctrl_rd_s, ctrl_wr_s, lo_wr_s, hi_rd_s, hi_wr_s;
  logic [31:0]      w1c_s, rd_lo_s, rd_hi_s, data_out_s;
  logic [WIDTH-1:0] entry_sel_s;
  logic             unused_s;

  assign busy_s       = (state_r != ST_IDLE);
  assign wr_s         = (data_write_n != WN_NONE);
  assign wmask_s      = lane_mask(data_write_n);
  assign commit_req_s = (address == ADDR_STAGE_HI) && (data_write_n == WN_B32);
  assign commit_go_s  = commit_req_s && !busy_s && !lock_r;

  always_comb begin
    ctrl_rd_s                        = 32'h0000_0000;
    ctrl_rd_s[CTRL_MODE]             = mode_r;
    ctrl_rd_s[CTRL_IRQ_EN]           = irq_en_r;
    ctrl_rd_s[CTRL_IDX_LSB +: IW]    = wr_idx_r;
    ctrl_rd_s[CTRL_LOCK]             = lock_r;
  end

  assign hi_rd_s   = 32'(stage_r[WIDTH-1:32]);
  assign ctrl_wr_s = (ctrl_rd_s & ~wmask_s) | (data_in & wmask_s);
  assign lo_wr_s   = (stage_r[31:0] & ~wmask_s) | (data_in & wmask_s);
  assign hi_wr_s   = (hi_rd_s & ~wmask_s) | (data_in & wmask_s);
  assign w1c_s     = (wr_s && address == ADDR_STATUS) ? (data_in & wmask_s) : 32'h0000_0000;

  assign entry_sel_s = config_bus[rd_sel_r*WIDTH +: WIDTH];
  assign rd_lo_s     = entry_sel_s[31:0];
  assign rd_hi_s     = 32'(entry_sel_s[WIDTH-1:32]);

  // CTRL, staging and RD_SEL; CTRL/staging are frozen while a commit runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= 1'b0;
      irq_en_r <= 1'b0;
      lock_r   <= 1'b0;
      wr_idx_r <= '0;
      rd_sel_r <= '0;
      stage_r  <= '0;
    end else begin
      if (wr_s && !busy_s && address == ADDR_CTRL) begin
        mode_r   <= ctrl_wr_s[CTRL_MODE];
        irq_en_r <= ctrl_wr_s[CTRL_IRQ_EN];
        wr_idx_r <= ctrl_wr_s[CTRL_IDX_LSB +: IW];
        lock_r   <= lock_r | ctrl_wr_s[CTRL_LOCK];
      end
      if (wr_s && !busy_s && address == ADDR_STAGE_LO) begin
        stage_r[31:0] <= lo_wr_s;
      end
      if (wr_s && !busy_s && address == ADDR_STAGE_HI) begin
        stage_r[WIDTH-1:32] <= hi_wr_s[WIDTH-33:0];
      end
      if (wr_s && address == ADDR_RD_SEL) begin
        rd_sel_r <= data_in[IW-1:0];
      end
    end
  end

  // Sticky status flags: a set in the same cycle as a W1C clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r     <= 1'b0;
      overrun_r  <= 1'b0;
      lock_err_r <= 1'b0;
      cnt_r      <= 8'd0;
    end else begin
      done_r     <= done_set_s | (done_r & ~w1c_s[STAT_DONE]);
      overrun_r  <= (commit_req_s && busy_s) | (overrun_r & ~w1c_s[STAT_OVERRUN]);
      lock_err_r <= (commit_req_s && !busy_s && lock_r) | (lock_err_r & ~w1c_s[STAT_LOCK_ERR]);
      if (done_set_s && cnt_r != 8'hFF) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  // Sequencer state and shift pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
    end
  end

  // Exactly one entry enable per SHIFT/INDEX cycle, none otherwise
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    en_s         = '0;
    shift_sel_s  = 1'b0;
    done_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (commit_go_s) begin
          if (mode_r) begin
            state_next_s = ST_INDEX;
          end else begin
            state_next_s = ST_SHIFT;
            ptr_next_s   = IW'(DEPTH - 1);
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        en_s[ptr_r] = 1'b1;
        shift_sel_s = 1'b1;
        if (ptr_r == '0) begin
          state_next_s = ST_DONE;
        end else begin
          ptr_next_s = ptr_r - 1'b1;
        end
      end
      ST_INDEX: begin
        en_s[wr_idx_r] = 1'b1;
        state_next_s   = ST_DONE;
      end
      ST_DONE: begin
        done_set_s   = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Read decode
  always_comb begin
    data_out_s = 32'h0000_0000;
    case (address)
      ADDR_CTRL:     data_out_s = ctrl_rd_s;
      ADDR_STAGE_LO: data_out_s = stage_r[31:0];
      ADDR_STAGE_HI: data_out_s = hi_rd_s;
      ADDR_STATUS:   data_out_s = {16'h0000, cnt_r, 4'h0, lock_err_r, overrun_r, done_r, busy_s};
      ADDR_RD_SEL:   data_out_s = 32'(rd_sel_r);
      ADDR_RD_LO:    data_out_s = rd_lo_s;
      ADDR_RD_HI:    data_out_s = rd_hi_s;
      default:       data_out_s = 32'h0000_0000;
    endcase
  end

  assign data_out       = data_out_s;
  assign data_ready     = 1'b1;
  assign user_interrupt = done_r & irq_en_r;
  assign unused_s       = ^{data_read_n, ctrl_wr_s, hi_wr_s, STAT_BUSY, STAT_CNT_LSB};

  prism_cfg_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_s),
    .shift_sel  (shift_sel_s),
    .staging    (stage_r),
    .config_bus (config_bus)
  );

endmodule

// File: tb/tb_prism_cfg_bank.sv
// Self-checking bench for prism_cfg_bank (WIDTH=48, DEPTH=8): register
// table, directed commit sequences and a randomized model comparison.
module tb_prism_cfg_bank;

  logic         clk, rst_n;
  logic [5:0]   address;
  logic [31:0]  data_in, data_out;
  logic [1:0]   data_write_n, data_read_n;
  logic         data_ready, user_interrupt;
  logic [383:0] config_bus;

  int n_vec = 0;
  int n_err = 0;

  prism_cfg_bank #(.WIDTH(48), .DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .config_bus     (config_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [47:0] m_e [8];
  logic [47:0] m_stg;
  logic        m_mode, m_irq, m_lock, m_done, m_ovr, m_lerr;
  logic [2:0]  m_idx, m_rdsel;
  logic [7:0]  m_cnt;

  typedef struct {
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [1:0]  wn;
    logic [5:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string nm, input logic [383:0] got, input logic [383:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a; data_in = d; data_write_n = wn; data_read_n = 2'b11;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address = a; data_write_n = 2'b11; data_read_n = 2'b10;
    #1;
    d = data_out;
    data_read_n = 2'b11;
  endtask

  // counts negedges with busy=1; bounded so a stuck sequencer shows as a bad count
  task automatic wait_idle(output int cyc);
    logic [31:0] s;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      rd(6'h0C, s);
      if (!s[0]) break;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    address = 6'h00; data_in = 32'h0; data_write_n = 2'b11; data_read_n = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) m_e[i] = 48'h0;
    m_stg = 48'h0; m_mode = 1'b0; m_irq = 1'b0; m_lock = 1'b0; m_done = 1'b0;
    m_ovr = 1'b0; m_lerr = 1'b0; m_idx = 3'd0; m_rdsel = 3'd0; m_cnt = 8'd0;
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [1:0] wn);
    int nb;
    logic [31:0] r;
    nb = (wn == 2'b00) ? 1 : (wn == 2'b01) ? 2 : (wn == 2'b10) ? 4 : 0;
    r = old;
    for (int b = 0; b < nb; b++) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mrd(input logic [5:0] a);
    case (a)
      6'h00: return {16'h0, m_lock, 4'h0, m_idx, 6'h0, m_irq, m_mode};
      6'h04: return m_stg[31:0];
      6'h08: return {16'h0, m_stg[47:32]};
      6'h0C: return {16'h0, m_cnt, 4'h0, m_lerr, m_ovr, m_done, 1'b0};
      6'h10: return {29'h0, m_rdsel};
      6'h14: return m_e[m_rdsel][31:0];
      6'h18: return {16'h0, m_e[m_rdsel][47:32]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [383:0] mbus();
    logic [383:0] b;
    for (int i = 0; i < 8; i++) b[i*48 +: 48] = m_e[i];
    return b;
  endfunction

  task automatic model_commit();
    if (m_mode) begin
      m_e[m_idx] = m_stg;
    end else begin
      for (int i = 7; i > 0; i--) m_e[i] = m_e[i-1];
      m_e[0] = m_stg;
    end
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    m_done = 1'b1;
  endtask

  initial begin
    logic [31:0]  d, tmp;
    logic [1:0]   wn;
    logic [383:0] e;
    int           cyc;
    logic [5:0]   ra_list [9];

    tbl[0]  = '{6'h00, 32'h0,         2'b11, 6'h00, 32'h0};
    tbl[1]  = '{6'h00, 32'h0,         2'b11, 6'h04, 32'h0};
    tbl[2]  = '{6'h00, 32'h0,         2'b11, 6'h0C, 32'h0};
    tbl[3]  = '{6'h00, 32'h0,         2'b11, 6'h1C, 32'h0};
    tbl[4]  = '{6'h04, 32'hDEADBEEF,  2'b10, 6'h04, 32'hDEADBEEF};
    tbl[5]  = '{6'h04, 32'h11223344,  2'b00, 6'h04, 32'hDEADBE44};
    tbl[6]  = '{6'h04, 32'h55667788,  2'b01, 6'h04, 32'hDEAD7788};
    tbl[7]  = '{6'h08, 32'hAAAA1234,  2'b01, 6'h08, 32'h00001234};
    tbl[8]  = '{6'h08, 32'hFFFFFF56,  2'b00, 6'h08, 32'h00001256};
    tbl[9]  = '{6'h00, 32'h00000703,  2'b01, 6'h00, 32'h00000703};
    tbl[10] = '{6'h00, 32'h00000500,  2'b00, 6'h00, 32'h00000700};
    tbl[11] = '{6'h00, 32'h00000000,  2'b01, 6'h00, 32'h00000000};
    tbl[12] = '{6'h10, 32'hFFFFFFFF,  2'b10, 6'h10, 32'h00000007};
    tbl[13] = '{6'h10, 32'h00000000,  2'b10, 6'h10, 32'h00000000};
    tbl[14] = '{6'h00, 32'h0,         2'b11, 6'h14, 32'h0};
    tbl[15] = '{6'h00, 32'h0,         2'b11, 6'h18, 32'h0};
    tbl[16] = '{6'h20, 32'hFFFFFFFF,  2'b10, 6'h20, 32'h0};
    tbl[17] = '{6'h0C, 32'hFFFFFFFF,  2'b10, 6'h0C, 32'h0};

    do_reset();
    chk("rst_config_bus", config_bus, 384'h0);
    chk("rst_irq", user_interrupt, 1'b0);
    chk("data_ready", data_ready, 1'b1);
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wn != 2'b11) wr(tbl[i].wa, tbl[i].wd, tbl[i].wn);
      rd(tbl[i].ra, d);
      chk($sformatf("tbl%0d", i), d, tbl[i].exp);
    end

    // shift mode: eight commits, first word ends up at the top
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      wr(6'h04, 32'h1000_0000 | k, 2'b10);
      wr(6'h08, k, 2'b10);
      wait_idle(cyc);
      chk($sformatf("shift_busy%0d", k), cyc, 9);
    end
    e = '0;
    for (int i = 0; i < 8; i++) e[i*48 +: 48] = {16'(8 - i), 32'h1000_0000 | (8 - i)};
    chk("shift_bus", config_bus, e);
    wr(6'h10, 32'd7, 2'b10); rd(6'h14, d); chk("shift_e7_lo", d, 32'h1000_0001);
    wr(6'h10, 32'd0, 2'b10); rd(6'h14, d); chk("shift_e0_lo", d, 32'h1000_0008);
    rd(6'h18, d); chk("shift_e0_hi", d, 32'h0000_0008);
    rd(6'h0C, d); chk("shift_status", d, 32'h0000_0802);

    // indexed mode
    do_reset();
    wr(6'h00, 32'h0000_0501, 2'b01);
    wr(6'h04, 32'h1234_5678, 2'b10);
    wr(6'h08, 32'h0000_ABCD, 2'b10);
    wait_idle(cyc);
    chk("idx_busy", cyc, 2);
    e = '0; e[5*48 +: 48] = 48'hABCD_1234_5678;
    chk("idx_bus", config_bus, e);
    wr(6'h10, 32'd5, 2'b10);
    rd(6'h14, d); chk("idx_rd_lo", d, 32'h1234_5678);
    rd(6'h18, d); chk("idx_rd_hi", d, 32'h0000_ABCD);

    // overrun: STAGE_HI commit write while busy is dropped
    do_reset();
    wr(6'h04, 32'h0000_0001, 2'b10);
    wr(6'h08, 32'h0000_0002, 2'b10);
    wr(6'h08, 32'h0000_0099, 2'b10);
    wait_idle(cyc);
    e = '0; e[47:0] = 48'h0002_0000_0001;
    chk("ovr_bus", config_bus, e);
    rd(6'h08, d); chk("ovr_stage_hi", d, 32'h2);
    rd(6'h0C, d); chk("ovr_status", d, 32'h0000_0106);
    wr(6'h0C, 32'h4, 2'b00);
    rd(6'h0C, d); chk("ovr_w1c", d, 32'h0000_0102);

    // lock: commit dropped, staging still written, lock sticky
    wr(6'h00, 32'h0000_8000, 2'b01);
    wr(6'h04, 32'h0000_00AA, 2'b10);
    wr(6'h08, 32'h0000_00BB, 2'b10);
    rd(6'h0C, d); chk("lock_status", d, 32'h0000_010A);
    @(negedge clk);
    chk("lock_bus", config_bus, e);
    rd(6'h08, d); chk("lock_stage_hi", d, 32'h0000_00BB);
    wr(6'h00, 32'h0000_0000, 2'b01);
    rd(6'h00, d); chk("lock_sticky", d, 32'h0000_8000);

    // interrupt and W1C landing on the DONE cycle
    do_reset();
    wr(6'h00, 32'h0000_0003, 2'b00);
    wr(6'h08, 32'h0000_0001, 2'b10);
    rd(6'h0C, d); chk("irq_index_st", d, 32'h1);
    chk("irq_low", user_interrupt, 1'b0);
    @(negedge clk);
    rd(6'h0C, d); chk("irq_done_st", d, 32'h1);
    wr(6'h0C, 32'h2, 2'b00);
    rd(6'h0C, d); chk("irq_set_wins", d, 32'h0000_0102);
    chk("irq_high", user_interrupt, 1'b1);
    wr(6'h0C, 32'h2, 2'b00);
    chk("irq_cleared", user_interrupt, 1'b0);

    // reset in the middle of a shift
    do_reset();
    wr(6'h00, 32'h0000_0301, 2'b01);
    wr(6'h04, 32'h0000_CAFE, 2'b10);
    wr(6'h08, 32'h0000_0077, 2'b10);
    wait_idle(cyc);
    wr(6'h00, 32'h0000_0000, 2'b01);
    wr(6'h08, 32'h0000_0011, 2'b10);
    repeat (4) @(negedge clk);
    chk("mid_nonzero", |config_bus, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", config_bus, 384'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rd(6'h0C, d); chk("mid_rst_status", d, 32'h0);
    chk("mid_rst_bus2", config_bus, 384'h0);

    // randomized operations against the model
    do_reset();
    ra_list = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h3C};
    for (int n = 0; n < 300; n++) begin
      d  = $urandom;
      wn = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 4))
        0: begin
          wr(6'h04, d, wn);
          m_stg[31:0] = lanes(m_stg[31:0], d, wn);
        end
        1: begin
          if ($urandom_range(0, 1) == 0) wn = 2'b10;
          wr(6'h08, d, wn);
          tmp = lanes({16'h0, m_stg[47:32]}, d, wn);
          m_stg[47:32] = tmp[15:0];
          if (wn == 2'b10) begin
            wait_idle(cyc);
            chk("rnd_busy", cyc, m_mode ? 2 : 9);
            model_commit();
            chk("rnd_bus", config_bus, mbus());
          end
        end
        2: begin
          d = d & 32'h0000_7FFF;
          wr(6'h00, d, wn);
          tmp = lanes(mrd(6'h00), d, wn);
          m_mode = tmp[0]; m_irq = tmp[1]; m_idx = tmp[10:8];
        end
        3: begin
          wr(6'h10, d, wn);
          m_rdsel = d[2:0];
        end
        default: begin
          wr(6'h0C, d, wn);
          if (d[1]) m_done = 1'b0;
          if (d[2]) m_ovr = 1'b0;
          if (d[3]) m_lerr = 1'b0;
        end
      endcase
      tmp[5:0] = ra_list[$urandom_range(0, 8)];
      rd(tmp[5:0], d);
      chk($sformatf("rnd_rd_%0h", tmp[5:0]), d, mrd(tmp[5:0]));
      chk("rnd_irq", user_interrupt, m_done & m_irq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
